arbiter_rr_n: RTL
=================

Name: arbiter_rr_n

Overview:
- N-input arbiter: merges NUM_REQ valid/data request channels into one registered output channel with a ready handshake.
- Parametrised successor to the two-input valid/stall arbiter.
- Adds a data path, a requester ID, downstream back-pressure and a selectable fixed-priority or round-robin policy.
- Sits between multiple producer stages and a single shared consumer (bus port, crypto core input, etc.).

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 8, width of each request payload.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (index 0 highest).
- ID_W, clog2(NUM_REQ), width of the granted-requester index; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_REQ  per-requester request valid.
- in_data  input  NUM_REQ*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- out_stall  output  NUM_REQ  per-requester stall; requester must hold valid/data while its bit is high.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  registered payload.
- out_id  output  ID_W  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.

Behaviour:
- Reset (async assert; deassertion synchronous to clk):
  - out_valid=0, out_data=0, out_id=0.
  - Round-robin pointer rr_ptr=0.
- Output-register state:
  - empty = !out_valid.
  - drain = out_valid && out_ready.
  - can_load = empty || drain.
- Grant selection (combinational, evaluated every cycle):
  - Fixed mode: lowest index i with in_valid[i]=1.
  - RR mode: first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - any_req = |in_valid.
- accept = can_load && any_req.
- out_stall[i] = in_valid[i] && !(accept && grant==i).
  - Combinational; never high for a non-requesting input.
- On a clk edge with accept:
  - out_valid<=1, out_data<=in_data[grant], out_id<=grant.
  - RR mode only: rr_ptr <= (grant==NUM_REQ-1) ? 0 : grant+1.
- On a clk edge with drain && !accept: out_valid<=0; out_data and out_id hold their last values.
- While out_valid && !out_ready:
  - out_valid, out_data and out_id are stable.
  - Every requesting input sees stall=1.
  - rr_ptr does not change.
- Latency: a request accepted in cycle T appears on the output in cycle T+1.
- Throughput: one beat per cycle when out_ready is held high (simultaneous drain and load).
- Fairness: in RR mode, with all inputs continuously valid, each requester is granted exactly once every NUM_REQ accepts.
- Fixed mode: rr_ptr is held at 0 and ignored.
- A requester that drops valid is skipped with no penalty; the pointer only moves on accept.
- Reset mid-transfer: the pending beat is discarded, out_valid falls immediately (async), and the pointer returns to 0.
- No data lost or duplicated: each accepted request appears exactly once on the output.

Decomposition:
- Package arb_pkg:
  - Mode constants ARB_MODE_FIXED=0, ARB_MODE_RR=1.
  - Function clog2 for ID_W.
  - Max NUM_REQ constant 16.
- Sub-module arb_pick (purely combinational):
  - Inputs: req vector and start index.
  - Outputs: grant index and any_req.
  - Implemented as rotate-right by start, lowest-set-bit priority encode, rotate back.
  - Fixed mode drives start=0.
- Top level holds the output register, the handshake logic and rr_ptr.

Test Plan:
- Reset and idle: assert reset during activity with out_valid=1 -> out_valid=0, out_id=0 within the same cycle; after release with no requests, out_stall=0000 and out_valid stays 0.
- Round-robin fairness: NUM_REQ=4, RR_MODE=1, all in_valid=1111, data i=8'hA0+i, out_ready=1 -> out_id sequence 0,1,2,3,0,1 on consecutive cycles; out_data A0,A1,A2,A3,A0; exactly one stall bit low per cycle.
- Fixed priority: RR_MODE=0, in_valid=1010 held, out_ready=1 -> out_id=1 every cycle and out_stall=1000 throughout; drop bit 1 -> out_id=3.
- Back-pressure: one beat accepted from requester 2 (data 8'h5C), then out_ready=0 for 3 cycles with in_valid=1111 -> out_valid=1, out_data=5C, out_id=2 stable; out_stall=1111; rr_ptr unchanged; raise out_ready -> next out_id=3 one cycle later.
- Sparse/skip: RR, rr_ptr=1, in_valid=0001 -> grant 0 and pointer becomes 1; then in_valid=0110 -> grant 1, then 2.
- Drain to empty: single request from 3, then in_valid=0 with out_ready=1 -> out_valid high one cycle then 0; out_data/out_id keep 3's values.

Source files
------------

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared constants and helpers for the N-input valid/data arbiter.
//
//   ARB_MODE_FIXED / ARB_MODE_RR : values for the arbiter RR_MODE parameter.
//   ARB_MAX_REQ                  : largest supported number of requesters.
//   clog2()                      : ceiling log2, used to size requester IDs.
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;
  localparam int ARB_MAX_REQ    = 16;

  // Ceiling log2 usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
//   Purely combinational grant picker. Returns the first set bit of req,
//   scanning upward from index start and wrapping modulo NUM_REQ.
//
//   Ports:
//     req     in   NUM_REQ  request vector
//     start   in   ID_W     index that has highest priority this cycle
//     grant   out  ID_W     selected requester (0 when no request)
//     any_req out  1        at least one request is present
// -----------------------------------------------------------------------------
module arb_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    start,
  output logic [ID_W-1:0]    grant,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [ID_W-1:0]      rot_idx;
  logic [ID_W:0]        grant_sum;

  // Rotate right by start: bit k of req_rot is req[(start + k) % NUM_REQ].
  assign req_dbl = {req, req} >> start;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  // Lowest set bit of the rotated vector. Scanning downward lets the last
  // assignment win, which is the lowest index.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    rot_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) rot_idx = ID_W'(k);
    end
  end

  // Rotate back: grant = (start + rot_idx) mod NUM_REQ. Both operands are
  // below NUM_REQ, so a single conditional subtract is enough.
  always_comb begin
    grant_sum = {1'b0, start} + {1'b0, rot_idx};
    if (grant_sum >= (ID_W+1)'(NUM_REQ)) begin
      grant_sum = grant_sum - (ID_W+1)'(NUM_REQ);
    end
    grant = grant_sum[ID_W-1:0];
  end

  assign any_req = |req;

endmodule

// File: rtl/arbiter_rr_n.sv
// -----------------------------------------------------------------------------
// arbiter_rr_n
//   Merges NUM_REQ valid/data request channels into one registered output
//   channel with a ready handshake. Policy is round-robin (RR_MODE = 1) or
//   fixed priority with index 0 highest (RR_MODE = 0). NUM_REQ legal range
//   is 2..ARB_MAX_REQ.
//
//   Ports:
//     clk        in   1               rising-edge clock
//     reset      in   1               asynchronous, active-high reset
//     in_valid   in   NUM_REQ         per-requester valid
//     in_data    in   NUM_REQ*DATA_W  payloads, requester i at [i*DATA_W +: DATA_W]
//     out_stall  out  NUM_REQ         requester must hold valid/data while high
//     out_valid  out  1               output register holds a beat
//     out_data   out  DATA_W          registered payload
//     out_id     out  ID_W            requester that supplied out_data
//     out_ready  in   1               consumer takes the beat when valid && ready
// -----------------------------------------------------------------------------
module arbiter_rr_n
  import arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  parameter  int RR_MODE = ARB_MODE_RR,
  localparam int ID_W    = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        out_stall,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_ready
);

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   pick_start;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   next_ptr;
  logic [DATA_W-1:0] grant_data;
  logic              any_req;
  logic              drain;
  logic              can_load;
  logic              accept;

  // Fixed priority always scans from requester 0; the pointer is ignored.
  assign pick_start = (RR_MODE == ARB_MODE_RR) ? rr_ptr : '0;

  arb_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (in_valid),
    .start   (pick_start),
    .grant   (grant),
    .any_req (any_req)
  );

  // Output register can take a new beat when empty or when its current
  // beat leaves this very cycle, giving one beat per cycle under ready.
  assign drain    = out_valid && out_ready;
  assign can_load = !out_valid || out_ready;
  assign accept   = can_load && any_req;

  assign grant_data = in_data[grant*DATA_W +: DATA_W];

  // Pointer moves just past the winner so it drops to lowest priority.
  assign next_ptr = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  // Every requester is stalled except the one accepted this cycle;
  // non-requesters never see stall because the base is in_valid itself.
  always_comb begin
    out_stall = in_valid;
    if (accept) out_stall[grant] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_id    <= grant;
        if (RR_MODE == ARB_MODE_RR) rr_ptr <= next_ptr;
      end else if (drain) begin
        // Data and ID keep their last values once the beat has left.
        out_valid <= 1'b0;
      end
    end
  end

endmodule
